// File: rtl/timer_pkg.sv
//------------------------------------------------------------------------------
// timer_pkg
//
// Purpose : Shared definitions for the MM:SS countdown core: controller state
//           encoding, BCD field widths, digit positions inside the packed
//           {min_tens, min_ones, sec_tens, sec_ones} word, and the load
//           sanitising (clamp) function.
//
// Contents:
//   BCD_W, DISP_W    - width of one BCD digit / of the packed MM:SS word
//   MT, MO, ST, SO   - digit index of min_tens, min_ones, sec_tens, sec_ones
//   state_t          - IDLE / RUN / PAUSE / EXPIRED
//   clamp_digit()    - limit a single digit to a maximum value
//   sanitize_bcd()   - clamp every digit of a loaded MM:SS word
//------------------------------------------------------------------------------
package timer_pkg;

    localparam int BCD_W  = 4;
    localparam int DISP_W = 16;

    // Digit positions, counted from the least-significant nibble.
    localparam int SO = 0;
    localparam int ST = 1;
    localparam int MO = 2;
    localparam int MT = 3;

    // Largest legal value of each digit class.
    localparam logic [BCD_W-1:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [BCD_W-1:0] DIGIT_MAX_5 = 4'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Limit one BCD digit to max_d.
    function automatic logic [BCD_W-1:0] clamp_digit(
        input logic [BCD_W-1:0] d,
        input logic [BCD_W-1:0] max_d
    );
        return (d > max_d) ? max_d : d;
    endfunction

    // Make an arbitrary 16-bit word a legal MM:SS value: any digit above 9
    // becomes 9 and the seconds-tens digit is capped at 5 (e.g. AB7C -> 9959).
    function automatic logic [DISP_W-1:0] sanitize_bcd(
        input logic [DISP_W-1:0] v
    );
        logic [DISP_W-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*BCD_W +: BCD_W] = clamp_digit(v[i*BCD_W +: BCD_W],
                                              (i == ST) ? DIGIT_MAX_5 : DIGIT_MAX_9);
        end
        return r;
    endfunction

endpackage

// File: rtl/mmss_bcd_dec.sv
//------------------------------------------------------------------------------
// mmss_bcd_dec
//
// Purpose : Purely combinational one-second decrement of a packed BCD MM:SS
//           value. Borrows ripple sec_ones (0->9), sec_tens (0->5),
//           min_ones (0->9) into min_tens. An input of 00:00 is returned
//           unchanged, so the count can never wrap below zero.
//
// Ports:
//   i_bcd   [15:0] in   current MM:SS, {min_tens, min_ones, sec_tens, sec_ones}
//   o_bcd   [15:0] out  i_bcd minus one second (saturating at 00:00)
//   o_zero         out  o_bcd is 00:00
//------------------------------------------------------------------------------
module mmss_bcd_dec
    import timer_pkg::*;
(
    input  logic [DISP_W-1:0] i_bcd,
    output logic [DISP_W-1:0] o_bcd,
    output logic              o_zero
);

    logic               w_borrow;
    logic [BCD_W-1:0]   w_digit;

    // NOTE: combinational blocks use blocking '=' so each statement sees the
    // value produced by the one before it (the borrow ripples through the loop).
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would make synthesis infer a latch.
        o_bcd    = i_bcd;
        w_borrow = (i_bcd != '0);
        w_digit  = '0;
        for (int i = 0; i < 4; i++) begin
            w_digit = i_bcd[i*BCD_W +: BCD_W];
            if (w_borrow) begin
                if (w_digit == '0) begin
                    // Digit underflows: reload with its maximum and keep borrowing.
                    o_bcd[i*BCD_W +: BCD_W] = (i == ST) ? DIGIT_MAX_5 : DIGIT_MAX_9;
                end else begin
                    o_bcd[i*BCD_W +: BCD_W] = w_digit - 4'd1;
                    w_borrow                = 1'b0;
                end
            end
        end
    end

    assign o_zero = (o_bcd == '0);

endmodule

// File: rtl/countdown_timer.sv
//------------------------------------------------------------------------------
// countdown_timer
//
// Purpose : Programmable MM:SS countdown core. Counts tick_10ms enable pulses
//           into whole seconds and decrements a BCD MM:SS value while running.
//           Offers load / start / pause / clear control and reports expiry as a
//           one-cycle done pulse plus a sticky expired level. All outputs are
//           registered.
//
// Parameters:
//   TICKS_PER_SEC  tick_10ms pulses per displayed second
//   SUB_W          width of the sub-second counter (2**SUB_W >= TICKS_PER_SEC)
//
// Ports:
//   clk              in   system clock
//   reset            in   asynchronous, active-high reset
//   tick_10ms        in   one-cycle enable pulse from the clock divider
//   load             in   pulse: capture (sanitised) load_bcd
//   load_bcd  [15:0] in   {min_tens, min_ones, sec_tens, sec_ones} BCD
//   start            in   pulse: begin or resume counting
//   pause            in   pulse: suspend counting
//   clear            in   pulse: return to idle showing 00:00
//   disp_bcd  [15:0] out  current time, same packing as load_bcd
//   running          out  high while counting
//   done             out  one-cycle pulse on the edge the count reaches 00:00
//   expired          out  high after expiry until load or clear
//
// Event priority within one cycle: clear > load > pause > start > tick.
//------------------------------------------------------------------------------
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int SUB_W         = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_10ms,
    input  logic              load,
    input  logic [DISP_W-1:0] load_bcd,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    output logic [DISP_W-1:0] disp_bcd,
    output logic              running,
    output logic              done,
    output logic              expired
);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

    // Registered state
    state_t             r_state;
    logic [DISP_W-1:0]  r_disp;
    logic [SUB_W-1:0]   r_sub;
    logic               r_running;
    logic               r_done;
    logic               r_expired;

    // Next-state values
    state_t             w_state_nxt;
    logic [DISP_W-1:0]  w_disp_nxt;
    logic [SUB_W-1:0]   w_sub_nxt;
    logic               w_done_nxt;
    logic               w_running_nxt;
    logic               w_expired_nxt;

    // Decrementer results and helpers
    logic [DISP_W-1:0]  w_dec_bcd;
    logic               w_dec_zero;
    logic               w_disp_zero;
    logic [DISP_W-1:0]  w_load_val;

    mmss_bcd_dec u_dec (
        .i_bcd  (r_disp),
        .o_bcd  (w_dec_bcd),
        .o_zero (w_dec_zero)
    );

    assign w_disp_zero = (r_disp == '0);
    assign w_load_val  = sanitize_bcd(load_bcd);

    //--------------------------------------------------------------------------
    // Next-state / next-output logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_disp_nxt  = r_disp;
        w_sub_nxt   = r_sub;
        w_done_nxt  = 1'b0;

        if (clear) begin
            w_state_nxt = IDLE;
            w_disp_nxt  = '0;
            w_sub_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Subcount is always zero here; a tick alongside start
                    // is deliberately not counted.
                    if (load) begin
                        w_disp_nxt = w_load_val;
                    end else if (start && !w_disp_zero) begin
                        w_state_nxt = RUN;
                    end
                end

                RUN: begin
                    // load and start have no effect while counting.
                    if (pause) begin
                        w_state_nxt = PAUSE;
                    end else if (tick_10ms) begin
                        if (r_sub == SUB_LAST) begin
                            w_sub_nxt  = '0;
                            w_disp_nxt = w_dec_bcd;
                            if (w_dec_zero) begin
                                w_state_nxt = EXPIRED;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_sub_nxt = r_sub + SUB_W'(1);
                        end
                    end
                end

                PAUSE: begin
                    if (load) begin
                        w_disp_nxt  = w_load_val;
                        w_sub_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else if (start) begin
                        // Resume with the retained subcount; this cycle's tick
                        // is not counted.
                        w_state_nxt = RUN;
                    end
                end

                EXPIRED: begin
                    if (load) begin
                        w_disp_nxt  = w_load_val;
                        w_sub_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                    w_disp_nxt  = '0;
                    w_sub_nxt   = '0;
                end
            endcase
        end

        // Status flags follow the state being entered so they are registered
        // alongside it.
        w_running_nxt = (w_state_nxt == RUN);
        w_expired_nxt = (w_state_nxt == EXPIRED);
    end

    //--------------------------------------------------------------------------
    // State and output registers
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_disp    <= '0;
            r_sub     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_disp    <= w_disp_nxt;
            r_sub     <= w_sub_nxt;
            r_running <= w_running_nxt;
            r_done    <= w_done_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    assign disp_bcd = r_disp;
    assign running  = r_running;
    assign done     = r_done;
    assign expired  = r_expired;

endmodule
